// File: rtl/wb_rr_arbiter_if.sv
// if_wb: pipelined Wishbone bundle shared by the arbiter's ports.
//   adr, cyc, stb, we, sel : request from the bus master
//   ack, stall             : response flow control from the slave
//   dat_s / dat_m          : data lanes. On the slave-facing modport dat_s is
//                            the master's write data and dat_m the read data
//                            returned to it; on the master-facing modport
//                            dat_m is the write data driven out and dat_s the
//                            read data coming back.
interface if_wb;
    logic [31:0] adr;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_s;
    logic [31:0] dat_m;
    logic        ack;
    logic        stall;

    modport slave  (input  adr, cyc, stb, we, sel, dat_s,
                    output ack, stall, dat_m);
    modport master (output adr, cyc, stb, we, sel, dat_m,
                    input  ack, stall, dat_s);
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-master, one-slave pipelined Wishbone arbiter feeding the
// cache inbus. The bus is granted per Wishbone cycle with round-robin
// fairness and held as long as the owner keeps cyc high. Accepted requests
// that are still waiting for their ack are counted so acks reach the owner
// and issue is throttled at MAXOUT outstanding.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset
//   in0      slave port for master 0 (instruction bus)
//   in1      slave port for master 1 (data bus)
//   out      master port towards the cache
//   grant_o  one-hot owner: 01 = in0, 10 = in1, 00 = idle
module wb_rr_arbiter #(
    parameter int MAXOUT = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    if_wb.slave        in0,
    if_wb.slave        in1,
    if_wb.master       out,
    output logic [1:0] grant_o
);
    localparam int CW = $clog2(MAXOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic          last, last_nx;
    logic [CW-1:0] outcnt, outcnt_nx;

    logic busy;
    logic own1;
    logic own_cyc;
    logic at_max;
    logic stb_fwd;
    logic accept;
    logic ack_fwd;

    assign busy    = (state != IDLE);
    assign own1    = (state == G1);
    assign own_cyc = own1 ? in1.cyc : in0.cyc;
    assign at_max  = (outcnt == CW'(MAXOUT));
    assign stb_fwd = busy && (own1 ? in1.stb : in0.stb) && !at_max;
    assign accept  = stb_fwd && !out.stall;
    // An ack with nothing outstanding is stray (late ack of an aborted or
    // reset cycle) and must not reach either master.
    assign ack_fwd = busy && out.ack && (outcnt != '0);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            last   <= 1'b1;
            outcnt <= '0;
        end else begin
            state  <= state_nx;
            last   <= last_nx;
            outcnt <= outcnt_nx;
        end
    end

    // Next state
    always_comb begin
        state_nx  = state;
        last_nx   = last;
        outcnt_nx = outcnt;
        case (state)
            // On a tie in0 wins only if in1 was granted last.
            IDLE: begin
                if (in0.cyc && (!in1.cyc || last)) state_nx = G0;
                else if (in1.cyc)                  state_nx = G1;
            end
            // Release hands over directly when the other master is waiting.
            G0: if (!in0.cyc) state_nx = in1.cyc ? G1 : IDLE;
            G1: if (!in1.cyc) state_nx = in0.cyc ? G0 : IDLE;
            default: state_nx = IDLE;
        endcase

        if (state_nx == G0)      last_nx = 1'b0;
        else if (state_nx == G1) last_nx = 1'b1;

        // Dropping cyc abandons whatever is still outstanding.
        if (!busy || !own_cyc)        outcnt_nx = '0;
        else if (accept && !ack_fwd)  outcnt_nx = outcnt + 1'b1;
        else if (!accept && ack_fwd)  outcnt_nx = outcnt - 1'b1;
    end

    // Outputs: pure combinational passthrough from the owner
    always_comb begin
        out.cyc   = busy && own_cyc;
        out.stb   = stb_fwd;
        out.adr   = own1 ? in1.adr   : in0.adr;
        out.we    = own1 ? in1.we    : in0.we;
        out.sel   = own1 ? in1.sel   : in0.sel;
        out.dat_m = own1 ? in1.dat_s : in0.dat_s;

        in0.stall = (state != G0) || out.stall || at_max;
        in1.stall = (state != G1) || out.stall || at_max;
        in0.ack   = (state == G0) && ack_fwd;
        in1.ack   = (state == G1) && ack_fwd;
        in0.dat_m = out.dat_s;
        in1.dat_m = out.dat_s;

        grant_o   = {state == G1, state == G0};
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios followed by a randomized phase
// checked against a cycle model written in terms of owner / last / count.
module tb_wb_rr_arbiter;
    localparam int MAXOUT = 4;

    logic       clk_i;
    logic       rst_i;
    logic [1:0] grant;

    if_wb in0();
    if_wb in1();
    if_wb out();

    wb_rr_arbiter #(.MAXOUT(MAXOUT)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .in0     (in0),
        .in1     (in1),
        .out     (out),
        .grant_o (grant)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int  m_own;
    int  m_last;
    int  m_cnt;
    bit  rc [2];
    bit  rs [2];
    logic [31:0] rad [2];
    bit  r_stall, r_ack, r_rst;
    bit  e_stb, e_cyc, e_ackf, e_acc;
    bit  e_st [2];
    bit  e_ak [2];
    logic [1:0] e_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_inputs();
        in0.cyc = 0; in0.stb = 0; in0.we = 0; in0.sel = 4'h0; in0.adr = '0; in0.dat_s = '0;
        in1.cyc = 0; in1.stb = 0; in1.we = 0; in1.sel = 4'h0; in1.adr = '0; in1.dat_s = '0;
        out.ack = 0; out.stall = 0; out.dat_s = '0;
    endtask

    task automatic do_reset();
        rst_i = 1;
        tick();
        tick();
        rst_i = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1;
        clr_inputs();
        do_reset();
        #1;
        // ---- reset state
        chk("rst_grant",  grant, 2'b00);
        chk("rst_cyc",    out.cyc, 0);
        chk("rst_stb",    out.stb, 0);
        chk("rst_stall0", in0.stall, 1);
        chk("rst_stall1", in1.stall, 1);
        chk("rst_cnt",    dut.outcnt, 0);

        // ---- single master, three pipelined reads
        in0.cyc = 1; in0.stb = 1; in0.adr = 32'h100;
        #1;
        chk("t1_stall_req", in0.stall, 1);
        chk("t1_cyc_req",   out.cyc, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            out.ack   = (i > 0);
            out.dat_s = 32'hA0 + 32'(i) - 32'd1;
            if (i < 3) begin in0.stb = 1; in0.adr = 32'h100 + 32'(4 * i); end
            else in0.stb = 0;
            #1;
            chk("t1_cyc",   out.cyc, 1);
            chk("t1_grant", grant, 2'b01);
            if (i < 3) begin
                chk("t1_adr", out.adr, 32'h100 + 32'(4 * i));
                chk("t1_stb", out.stb, 1);
            end
            if (i > 0) begin
                chk("t1_ack",  in0.ack, 1);
                chk("t1_data", in0.dat_m, 32'hA0 + 32'(i) - 32'd1);
            end
        end
        tick();
        out.ack = 0;
        #1;
        chk("t1_cnt0", dut.outcnt, 0);
        chk("t1_noack", in0.ack, 0);
        in0.cyc = 0;
        tick();

        // ---- tie and fairness
        do_reset();
        in0.cyc = 1; in1.cyc = 1;
        tick();
        #1;
        chk("t2_first", grant, 2'b01);
        in0.cyc = 0;
        #1;
        chk("t2_rel_cyc", out.cyc, 0);
        tick();
        #1;
        chk("t2_handover", grant, 2'b10);
        chk("t2_ho_cyc",   out.cyc, 1);
        in1.cyc = 0;
        tick();
        #1;
        chk("t2_idle", grant, 2'b00);
        in0.cyc = 1; in1.cyc = 1;
        tick();
        #1;
        chk("t2_alt", grant, 2'b01);
        in0.cyc = 0; in1.cyc = 0;
        tick();

        // ---- throttle at MAXOUT
        in1.cyc = 1; in1.stb = 1;
        tick();
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t3_stb",   out.stb, (k < 4) ? 1 : 0);
            chk("t3_stall", in1.stall, (k >= 4) ? 1 : 0);
            tick();
        end
        out.ack = 1;
        #1;
        chk("t3_ack_fwd", in1.ack, 1);
        chk("t3_full_stb", out.stb, 0);
        tick();
        #1;
        chk("t3_cnt3", dut.outcnt, 3);
        chk("t3_both_stb", out.stb, 1);
        tick();
        out.ack = 0;
        #1;
        chk("t3_both_cnt", dut.outcnt, 3);
        chk("t3_one_more", out.stb, 1);
        tick();
        #1;
        chk("t3_cnt4",  dut.outcnt, 4);
        chk("t3_stop",  out.stb, 0);
        chk("t3_stall1", in1.stall, 1);
        in1.cyc = 0; in1.stb = 0;
        #1;
        chk("t3_rel_cyc", out.cyc, 0);
        tick();
        #1;
        chk("t3_rel_cnt", dut.outcnt, 0);

        // ---- abort with outstanding requests, then stray ack
        in0.cyc = 1; in0.stb = 1;
        tick();
        tick();
        tick();
        in0.cyc = 0; in0.stb = 0;
        #1;
        chk("t4_cnt2",   dut.outcnt, 2);
        chk("t4_abort",  out.cyc, 0);
        tick();
        out.ack = 1;
        #1;
        chk("t4_stray0", in0.ack, 0);
        chk("t4_stray1", in1.ack, 0);
        chk("t4_cnt0",   dut.outcnt, 0);
        tick();
        out.ack = 0;
        #1;
        chk("t4_cnt0b",  dut.outcnt, 0);

        // ---- reset mid-operation
        in1.cyc = 1; in1.stb = 1;
        tick();
        tick();
        tick();
        tick();
        in1.stb = 0;
        #1;
        chk("t5_cnt3",  dut.outcnt, 3);
        chk("t5_grant", grant, 2'b10);
        rst_i = 1;
        tick();
        rst_i = 0;
        in0.cyc = 1;
        out.ack = 1;
        #1;
        chk("t5_grant0", grant, 2'b00);
        chk("t5_cyc0",   out.cyc, 0);
        chk("t5_stall0", in0.stall, 1);
        chk("t5_stall1", in1.stall, 1);
        chk("t5_noack",  in1.ack, 0);
        tick();
        out.ack = 0;
        #1;
        chk("t5_tie", grant, 2'b01);
        in0.cyc = 0; in1.cyc = 0;
        tick();

        // ---- write passthrough while in0 waits
        in0.cyc = 1;
        in1.cyc = 1; in1.stb = 1; in1.we = 1; in1.sel = 4'b0011;
        in1.adr = 32'h2000; in1.dat_s = 32'hDEADBEEF;
        #1;
        chk("t6_wait0", in0.stall, 1);
        tick();
        #1;
        chk("t6_grant", grant, 2'b10);
        chk("t6_adr",   out.adr, 32'h2000);
        chk("t6_dat",   out.dat_m, 32'hDEADBEEF);
        chk("t6_sel",   out.sel, 4'b0011);
        chk("t6_we",    out.we, 1);
        chk("t6_stb",   out.stb, 1);
        chk("t6_st0",   in0.stall, 1);
        tick();
        in1.stb = 0; out.ack = 1;
        #1;
        chk("t6_ack1",  in1.ack, 1);
        chk("t6_ack0",  in0.ack, 0);
        chk("t6_st0b",  in0.stall, 1);
        tick();
        out.ack = 0; in1.cyc = 0; in1.we = 0;
        #1;
        chk("t6_st0c",  in0.stall, 1);
        tick();
        #1;
        chk("t6_ho",    grant, 2'b01);
        chk("t6_ho_cyc", out.cyc, 1);
        in0.cyc = 0;
        tick();

        // ---- randomized phase against the model
        clr_inputs();
        do_reset();
        m_own = -1; m_last = 1; m_cnt = 0;
        rc[0] = 0; rc[1] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                rc[i]  = rc[i] ? ($urandom_range(7) != 0) : ($urandom_range(2) == 0);
                rs[i]  = $urandom_range(3) != 0;
                rad[i] = $urandom;
            end
            r_stall = $urandom_range(3) == 0;
            r_ack   = $urandom_range(2) == 0;
            r_rst   = $urandom_range(63) == 0;
            in0.cyc = rc[0]; in0.stb = rs[0]; in0.adr = rad[0];
            in1.cyc = rc[1]; in1.stb = rs[1]; in1.adr = rad[1];
            out.stall = r_stall; out.ack = r_ack; out.dat_s = $urandom;
            rst_i = r_rst;
            #1;
            if (m_own < 0) begin
                e_cyc = 0; e_stb = 0; e_gnt = 2'b00;
                e_st[0] = 1; e_st[1] = 1; e_ak[0] = 0; e_ak[1] = 0;
                e_ackf = 0;
            end else begin
                e_cyc  = rc[m_own];
                e_stb  = rs[m_own] && (m_cnt < MAXOUT);
                e_gnt  = (m_own == 0) ? 2'b01 : 2'b10;
                e_ackf = r_ack && (m_cnt > 0);
                e_st[m_own]     = r_stall || (m_cnt == MAXOUT);
                e_st[1 - m_own] = 1;
                e_ak[m_own]     = e_ackf;
                e_ak[1 - m_own] = 0;
                chk("r_adr", out.adr, rad[m_own]);
            end
            e_acc = e_stb && !r_stall;
            chk("r_grant", grant, e_gnt);
            chk("r_cyc",   out.cyc, e_cyc);
            chk("r_stb",   out.stb, e_stb);
            chk("r_st0",   in0.stall, e_st[0]);
            chk("r_st1",   in1.stall, e_st[1]);
            chk("r_ack0",  in0.ack, e_ak[0]);
            chk("r_ack1",  in1.ack, e_ak[1]);
            chk("r_cnt",   dut.outcnt, m_cnt);

            if (r_rst) begin
                m_own = -1; m_last = 1; m_cnt = 0;
            end else if (m_own < 0) begin
                if (rc[0] && rc[1]) m_own = 1 - m_last;
                else if (rc[0])     m_own = 0;
                else if (rc[1])     m_own = 1;
                if (m_own >= 0) m_last = m_own;
                m_cnt = 0;
            end else if (!rc[m_own]) begin
                m_cnt = 0;
                if (rc[1 - m_own]) begin
                    m_own  = 1 - m_own;
                    m_last = m_own;
                end else begin
                    m_own = -1;
                end
            end else begin
                m_cnt = m_cnt + int'(e_acc) - int'(e_ackf);
            end
            tick();
        end
        rst_i = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
